// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues credit-limited in-order
// requests to instruction memory and buffers returned words with their PCs.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_src_i,
  input  logic [31:0] pc_target_addr_i,
  input  logic        stall_f_i,
  output logic        imem_req_valid_o,
  output logic [31:0] imem_req_addr_o,
  input  logic        imem_req_ready_i,
  input  logic        imem_resp_valid_i,
  input  logic [31:0] imem_resp_data_i,
  output logic        if_valid_o,
  output logic [31:0] if_instr_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_pc_plus_4_o
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam logic [CNT_W:0] CREDITS = (CNT_W + 1)'(BUF_DEPTH);

  logic [31:0]      fetch_pc;
  logic [31:0]      tag_mem [BUF_DEPTH];
  logic [PTR_W-1:0] tag_wr_ptr;
  logic [PTR_W-1:0] tag_rd_ptr;
  logic [CNT_W-1:0] inflight;
  logic [CNT_W-1:0] drop_cnt;

  logic [31:0]      buf_pc    [BUF_DEPTH];
  logic [31:0]      buf_instr [BUF_DEPTH];
  logic [PTR_W-1:0] buf_wr_ptr;
  logic [PTR_W-1:0] buf_rd_ptr;
  logic [CNT_W-1:0] buf_count;

  logic [CNT_W:0]   credit_used;
  logic             req_fire;
  logic             resp_fire;
  logic             resp_keep;
  logic             buf_pop;
  logic             unused_addr_bits;

  // Stale in-flight slots still hold credit until their responses return.
  assign credit_used      = {1'b0, inflight} + {1'b0, buf_count};
  assign imem_req_valid_o = !rst && !pc_src_i && (credit_used < CREDITS);
  assign imem_req_addr_o  = fetch_pc;

  assign req_fire  = imem_req_valid_o && imem_req_ready_i;
  assign resp_fire = imem_resp_valid_i && (inflight != '0);
  assign resp_keep = resp_fire && !pc_src_i && (drop_cnt == '0);
  assign buf_pop   = if_valid_o && !stall_f_i && !pc_src_i;

  assign unused_addr_bits = ^pc_target_addr_i[1:0];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc   <= RESET_PC;
      tag_wr_ptr <= '0;
      tag_rd_ptr <= '0;
      inflight   <= '0;
      drop_cnt   <= '0;
      buf_wr_ptr <= '0;
      buf_rd_ptr <= '0;
      buf_count  <= '0;
    end else begin
      inflight <= inflight + CNT_W'(req_fire) - CNT_W'(resp_fire);
      if (req_fire) begin
        tag_wr_ptr <= tag_wr_ptr + 1'b1;
        fetch_pc   <= fetch_pc + 32'd4;
      end
      if (resp_fire)
        tag_rd_ptr <= tag_rd_ptr + 1'b1;

      if (pc_src_i) begin
        fetch_pc   <= {pc_target_addr_i[31:2], 2'b00};
        drop_cnt   <= inflight - CNT_W'(resp_fire);
        buf_wr_ptr <= '0;
        buf_rd_ptr <= '0;
        buf_count  <= '0;
      end else begin
        if (resp_fire && (drop_cnt != '0))
          drop_cnt <= drop_cnt - 1'b1;
        if (resp_keep)
          buf_wr_ptr <= buf_wr_ptr + 1'b1;
        if (buf_pop)
          buf_rd_ptr <= buf_rd_ptr + 1'b1;
        buf_count <= buf_count + CNT_W'(resp_keep) - CNT_W'(buf_pop);
      end
    end
  end

  // NOTE: storage arrays carry no reset; pointers and counts define validity
  // and empty outputs are forced to zero below.
  always_ff @(posedge clk) begin
    if (req_fire)
      tag_mem[tag_wr_ptr] <= fetch_pc;
    if (resp_keep && !rst) begin
      buf_pc[buf_wr_ptr]    <= tag_mem[tag_rd_ptr];
      buf_instr[buf_wr_ptr] <= imem_resp_data_i;
    end
  end

  assign if_valid_o     = (buf_count != '0);
  assign if_instr_o     = if_valid_o ? buf_instr[buf_rd_ptr] : 32'h0;
  assign if_pc_o        = if_valid_o ? buf_pc[buf_rd_ptr] : 32'h0;
  assign if_pc_plus_4_o = if_valid_o ? buf_pc[buf_rd_ptr] + 32'd4 : 32'h0;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a cycle-by-cycle vector table followed by a
// hand-driven stall/credit/drain sequence with a small memory responder.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pc_src = 1'b0;
  logic [31:0] target = '0;
  logic        stall = 1'b0;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        ready = 1'b0;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = '0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus_4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk              (clk),
    .rst              (rst),
    .pc_src_i         (pc_src),
    .pc_target_addr_i (target),
    .stall_f_i        (stall),
    .imem_req_valid_o (req_valid),
    .imem_req_addr_o  (req_addr),
    .imem_req_ready_i (ready),
    .imem_resp_valid_i(rvalid),
    .imem_resp_data_i (rdata),
    .if_valid_o       (if_valid),
    .if_instr_o       (if_instr),
    .if_pc_o          (if_pc),
    .if_pc_plus_4_o   (if_pc_plus_4)
  );

  typedef struct {
    logic        rst, ready, rvalid;
    logic [31:0] rdata;
    logic        stall, pc_src;
    logic [31:0] target;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_ifv;
    logic [31:0] e_pc, e_instr;
  } vec_t;

  localparam int NVEC = 35;
  vec_t vecs [NVEC];

  function automatic vec_t mk(logic r, logic rd, logic rv, logic [31:0] dat,
                              logic st, logic ps, logic [31:0] tg,
                              logic eq, logic [31:0] ea,
                              logic ev, logic [31:0] ep, logic [31:0] ei);
    vec_t v;
    v.rst = r; v.ready = rd; v.rvalid = rv; v.rdata = dat;
    v.stall = st; v.pc_src = ps; v.target = tg;
    v.e_req = eq; v.e_addr = ea; v.e_ifv = ev; v.e_pc = ep; v.e_instr = ei;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  logic [31:0] resp_q [$];
  int          fires;
  int          pops;
  logic [31:0] exp_pc;

  // Responder for the hand-driven phase: one response per accepted request,
  // presented the cycle after acceptance, data derived from the address.
  task automatic drive_resp();
    if (resp_q.size() > 0) begin
      rvalid = 1'b1;
      rdata  = resp_q[0] + 32'h1000_0013;
      void'(resp_q.pop_front());
    end else begin
      rvalid = 1'b0;
      rdata  = '0;
    end
  endtask

  initial begin
    //          rst rdy rv data          st ps target        req addr          ifv pc            instr
    vecs[0]  = mk(1, 1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0);
    vecs[1]  = mk(0, 1, 0, 32'h0,        0, 0, 32'h0,        1, 32'h0,        0, 32'h0,        32'h0);
    vecs[2]  = mk(0, 1, 1, 32'h00500093, 0, 0, 32'h0,        1, 32'h4,        0, 32'h0,        32'h0);
    vecs[3]  = mk(0, 1, 1, 32'h00A00113, 1, 0, 32'h0,        0, 32'h0,        1, 32'h0,        32'h00500093);
    vecs[4]  = mk(0, 1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        1, 32'h0,        32'h00500093);
    vecs[5]  = mk(0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h8,        1, 32'h4,        32'h00A00113);
    vecs[6]  = mk(0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h8,        0, 32'h0,        32'h0);
    vecs[7]  = mk(0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h8,        0, 32'h0,        32'h0);
    vecs[8]  = mk(0, 1, 0, 32'h0,        0, 0, 32'h0,        1, 32'h8,        0, 32'h0,        32'h0);
    vecs[9]  = mk(0, 1, 1, 32'h00308193, 0, 0, 32'h0,        1, 32'hC,        0, 32'h0,        32'h0);
    vecs[10] = mk(0, 1, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        1, 32'h8,        32'h00308193);
    vecs[11] = mk(0, 1, 1, 32'h00418213, 1, 0, 32'h0,        0, 32'h0,        1, 32'h8,        32'h00308193);
    vecs[12] = mk(0, 1, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        1, 32'h8,        32'h00308193);
    vecs[13] = mk(0, 1, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        1, 32'h8,        32'h00308193);
    vecs[14] = mk(0, 1, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        1, 32'h8,        32'h00308193);
    vecs[15] = mk(0, 1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        1, 32'h8,        32'h00308193);
    vecs[16] = mk(0, 1, 0, 32'h0,        0, 0, 32'h0,        1, 32'h10,       1, 32'hC,        32'h00418213);
    vecs[17] = mk(0, 1, 0, 32'h0,        0, 0, 32'h0,        1, 32'h14,       0, 32'h0,        32'h0);
    vecs[18] = mk(0, 1, 0, 32'h0,        0, 1, 32'h100,      0, 32'h0,        0, 32'h0,        32'h0);
    vecs[19] = mk(0, 1, 1, 32'hDEAD0001, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0);
    vecs[20] = mk(0, 1, 1, 32'hDEAD0002, 0, 0, 32'h0,        1, 32'h100,      0, 32'h0,        32'h0);
    vecs[21] = mk(0, 0, 1, 32'h00000013, 0, 0, 32'h0,        1, 32'h104,      0, 32'h0,        32'h0);
    vecs[22] = mk(0, 1, 0, 32'h0,        1, 0, 32'h0,        1, 32'h104,      1, 32'h100,      32'h00000013);
    vecs[23] = mk(0, 1, 1, 32'hBAD00104, 1, 1, 32'h103,      0, 32'h0,        1, 32'h100,      32'h00000013);
    vecs[24] = mk(0, 1, 0, 32'h0,        1, 0, 32'h0,        1, 32'h100,      0, 32'h0,        32'h0);
    vecs[25] = mk(0, 0, 1, 32'hCAFE0100, 1, 0, 32'h0,        1, 32'h104,      0, 32'h0,        32'h0);
    vecs[26] = mk(0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h104,      1, 32'h100,      32'hCAFE0100);
    vecs[27] = mk(0, 1, 0, 32'h0,        0, 0, 32'h0,        1, 32'h104,      0, 32'h0,        32'h0);
    vecs[28] = mk(1, 1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0);
    vecs[29] = mk(0, 0, 1, 32'hBADBAD00, 0, 0, 32'h0,        1, 32'h0,        0, 32'h0,        32'h0);
    vecs[30] = mk(0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h0,        0, 32'h0,        32'h0);
    vecs[31] = mk(0, 0, 0, 32'h0,        0, 1, 32'hFFFFFFFC, 0, 32'h0,        0, 32'h0,        32'h0);
    vecs[32] = mk(0, 1, 0, 32'h0,        0, 0, 32'h0,        1, 32'hFFFFFFFC, 0, 32'h0,        32'h0);
    vecs[33] = mk(0, 0, 1, 32'h00000073, 0, 0, 32'h0,        1, 32'h0,        0, 32'h0,        32'h0);
    vecs[34] = mk(0, 0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h0,        1, 32'hFFFFFFFC, 32'h00000073);

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      rst = vecs[i].rst; ready = vecs[i].ready; rvalid = vecs[i].rvalid;
      rdata = vecs[i].rdata; stall = vecs[i].stall; pc_src = vecs[i].pc_src;
      target = vecs[i].target;
      #1;
      check($sformatf("v%0d req_valid", i), 32'(req_valid), 32'(vecs[i].e_req));
      if (vecs[i].e_req)
        check($sformatf("v%0d req_addr", i), req_addr, vecs[i].e_addr);
      check($sformatf("v%0d if_valid", i), 32'(if_valid), 32'(vecs[i].e_ifv));
      check($sformatf("v%0d if_pc", i), if_pc, vecs[i].e_pc);
      check($sformatf("v%0d if_instr", i), if_instr, vecs[i].e_instr);
      check($sformatf("v%0d if_pc_plus_4", i), if_pc_plus_4,
            vecs[i].e_ifv ? vecs[i].e_pc + 32'd4 : 32'h0);
    end

    // Credit limit under a long stall, then in-order drain.
    @(negedge clk);
    rst = 1'b1; pc_src = 1'b0; stall = 1'b0; ready = 1'b0; rvalid = 1'b0;
    @(negedge clk);
    rst = 1'b0; stall = 1'b1; ready = 1'b1;
    resp_q.delete();
    fires = 0;
    for (int c = 0; c < 8; c++) begin
      drive_resp();
      #1;
      if (req_valid && ready) begin
        resp_q.push_back(req_addr);
        fires++;
      end
      if (c >= 3) begin
        check($sformatf("stall c%0d if_pc held", c), if_pc, 32'h0);
        check($sformatf("stall c%0d if_instr held", c), if_instr, 32'h1000_0013);
      end
      @(negedge clk);
    end
    check("stall fetch count", 32'(fires), 32'd2);
    check("stall req_valid low", 32'(req_valid), 32'd0);

    stall  = 1'b0;
    pops   = 0;
    exp_pc = 32'h0;
    for (int c = 0; c < 20 && pops < 4; c++) begin
      drive_resp();
      #1;
      if (req_valid && ready)
        resp_q.push_back(req_addr);
      if (if_valid) begin
        check($sformatf("drain pop%0d pc", pops), if_pc, exp_pc);
        check($sformatf("drain pop%0d instr", pops), if_instr, exp_pc + 32'h1000_0013);
        exp_pc += 32'd4;
        pops++;
      end
      @(negedge clk);
    end
    check("drain pop count", 32'(pops), 32'd4);
    rvalid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
